// File: rtl/mdio_master.sv
// Clause-45 MDIO station-management initiator: serialises one 64-bit management frame per command,
// generates MDC from the system clock and returns read data / write completion on a response strobe.
module mdio_master #(
  parameter int HALF_PERIOD = 50,
  parameter int PRE_BITS    = 32
) (
  input  logic        clk156_i,
  input  logic        reset_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [4:0]  cmd_prtad_i,
  input  logic [4:0]  cmd_devad_i,
  input  logic [15:0] cmd_data_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        mdc_o,
  output logic        mdio_o,
  output logic        mdio_oe_o,
  input  logic        mdio_i
);

  localparam int              PH_W     = $clog2(HALF_PERIOD);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(HALF_PERIOD - 1);
  localparam logic [4:0]      PRE_LAST = 5'(PRE_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic            half_q, half_d;
  logic [31:0]     tx_q, tx_d;
  logic            rd_q, rd_d;
  logic [14:0]     rx_q;
  logic            ta_err_q;
  logic            sync1_q, sync2_q;
  logic            mdc_d, mdio_d, oe_d, ready_d, rsp_valid_d;

  logic accept, busy, half_tick, bit_end;

  assign accept    = cmd_valid_i && cmd_ready_o;
  assign busy      = (state_q != S_IDLE);
  assign half_tick = busy && (ph_q == PH_LAST);
  assign bit_end   = half_tick && half_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk156_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: defaults first so no path through this block leaves a variable unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_PRE;
          cnt_d   = PRE_LAST;
        end
      end
      S_PRE, S_HDR, S_TA, S_DATA: begin
        if (bit_end) begin
          if (cnt_q != 5'd0) begin
            cnt_d = cnt_q - 5'd1;
          end else begin
            case (state_q)
              S_PRE:   begin state_d = S_HDR;  cnt_d = 5'd13; end
              S_HDR:   begin state_d = S_TA;   cnt_d = 5'd1;  end
              S_TA:    begin state_d = S_DATA; cnt_d = 5'd15; end
              default: begin state_d = S_GAP;  cnt_d = 5'd0;  end
            endcase
          end
        end
      end
      S_GAP: begin
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered pins and the bit-level datapath, derived from the next state.
  always_comb begin
    ph_d   = (!busy || half_tick) ? '0 : ph_q + 1'b1;
    half_d = half_q;
    if (state_d == S_IDLE) half_d = 1'b0;
    else if (half_tick)    half_d = ~half_q;

    tx_d = tx_q;
    rd_d = rd_q;
    if (accept) begin
      tx_d = {2'b00, cmd_op_i, cmd_prtad_i, cmd_devad_i, 2'b10, cmd_data_i};
      rd_d = cmd_op_i[1];
    end else if (bit_end && (state_q inside {S_HDR, S_TA, S_DATA})) begin
      tx_d = {tx_q[30:0], 1'b0};
    end

    // A read releases the line from the first turnaround bit onwards.
    oe_d = (state_d inside {S_PRE, S_HDR}) ||
           ((state_d inside {S_TA, S_DATA}) && !rd_d);
    mdio_d = 1'b1;
    if (oe_d && (state_d inside {S_HDR, S_TA, S_DATA})) mdio_d = tx_d[31];
    mdc_d       = (state_d inside {S_PRE, S_HDR, S_TA, S_DATA}) ? half_d : 1'b0;
    ready_d     = (state_d == S_IDLE);
    rsp_valid_d = bit_end && (state_q == S_DATA) && (cnt_q == 5'd0);
  end

  always_ff @(posedge clk156_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ph_q        <= '0;
      half_q      <= 1'b0;
      tx_q        <= '0;
      rd_q        <= 1'b0;
      rx_q        <= '0;
      ta_err_q    <= 1'b0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
      mdc_o       <= 1'b0;
      mdio_o      <= 1'b1;
      mdio_oe_o   <= 1'b0;
    end else begin
      ph_q        <= ph_d;
      half_q      <= half_d;
      tx_q        <= tx_d;
      rd_q        <= rd_d;
      sync1_q     <= mdio_i;
      sync2_q     <= sync1_q;
      cmd_ready_o <= ready_d;
      mdc_o       <= mdc_d;
      mdio_o      <= mdio_d;
      mdio_oe_o   <= oe_d;
      rsp_valid_o <= rsp_valid_d;

      // Input is sampled on the last cycle of each MDC high phase.
      if (bit_end && (state_q == S_TA) && (cnt_q == 5'd0)) ta_err_q <= sync2_q;
      if (bit_end && (state_q == S_DATA)) rx_q <= {rx_q[13:0], sync2_q};

      if (rsp_valid_d) begin
        rsp_data_o <= rd_q ? {rx_q, sync2_q} : 16'h0000;
        rsp_err_o  <= rd_q ? ta_err_q : 1'b0;
      end
    end
  end

endmodule
